// File: rtl/time_counter.sv
// BCD hh:mm:ss timekeeping core clocked by CP; CP_1Hz_in and the adjust levels are synchronised data inputs.
// Optional 12-hour AM/PM mode with pm output is enabled by defining CLK_12H_EN.
module time_counter #(
  parameter logic [7:0] INIT_HOUR = 8'h00,
  parameter logic [7:0] INIT_MIN  = 8'h00,
  localparam int unsigned DW = 4,
  localparam int unsigned FW = 2 * DW
) (
  input  logic          CP,
  input  logic          _CR,
  input  logic          CP_1Hz_in,
  input  logic          adj_min,
  input  logic          adj_hour,
  input  logic          hold,
  output logic [DW-1:0] sec_l,
  output logic [DW-1:0] sec_h,
  output logic [DW-1:0] min_l,
  output logic [DW-1:0] min_h,
  output logic [DW-1:0] hour_l,
  output logic [DW-1:0] hour_h,
  output logic          sec_pulse,
  output logic          day_carry
`ifdef CLK_12H_EN
  ,
  output logic          pm
`endif
);

  localparam int unsigned NSYNC = 3;

  logic [NSYNC-1:0] meta_q, sync_q, prev_q;
  logic [FW-1:0]    sec_q, sec_d;
  logic [FW-1:0]    min_q, min_d;
  logic [FW-1:0]    hour_q, hour_d;
  logic             sec_pulse_q, sec_pulse_d;
  logic             day_carry_q, day_carry_d;
`ifdef CLK_12H_EN
  logic             pm_q, pm_d;
`endif

  logic tick, adj_min_e, adj_hour_e;
  logic tick_apply, any_event;
  logic sec_wrap, min_tick, min_wrap, hour_inc, hour_last;

  // 00-59 field: out-of-range digits are zeroed
  function automatic logic [FW-1:0] clean60(input logic [FW-1:0] v);
    logic [DW-1:0] h, l;
    h = (v[FW-1:DW] > 4'd5) ? 4'd0 : v[FW-1:DW];
    l = (v[DW-1:0]  > 4'd9) ? 4'd0 : v[DW-1:0];
    return {h, l};
  endfunction

  function automatic logic [FW-1:0] next60(input logic [FW-1:0] v);
    logic [FW-1:0] c;
    c = clean60(v);
    if (c != v)                return c;
    if (v == 8'h59)            return 8'h00;
    if (v[DW-1:0] == 4'd9)     return {v[FW-1:DW] + 4'd1, 4'd0};
    return {v[FW-1:DW], v[DW-1:0] + 4'd1};
  endfunction

`ifdef CLK_12H_EN
  // 12-hour field 01-12; digit 0 does not exist as an hour so corruption lands on 12
  function automatic logic [FW-1:0] clean_hour(input logic [FW-1:0] v);
    logic ok;
    ok = ((v[FW-1:DW] == 4'd0) && (v[DW-1:0] >= 4'd1) && (v[DW-1:0] <= 4'd9)) ||
         ((v[FW-1:DW] == 4'd1) && (v[DW-1:0] <= 4'd2));
    return ok ? v : 8'h12;
  endfunction

  function automatic logic [FW-1:0] next_hour(input logic [FW-1:0] v);
    logic [FW-1:0] c;
    c = clean_hour(v);
    if (c != v)                return c;
    if (v == 8'h12)            return 8'h01;
    if (v[DW-1:0] == 4'd9)     return 8'h10;
    return {v[FW-1:DW], v[DW-1:0] + 4'd1};
  endfunction
`else
  // 24-hour field 00-23
  function automatic logic [FW-1:0] clean_hour(input logic [FW-1:0] v);
    logic [DW-1:0] h, l;
    h = (v[FW-1:DW] > 4'd2) ? 4'd0 : v[FW-1:DW];
    l = ((v[DW-1:0] > 4'd9) || ((h == 4'd2) && (v[DW-1:0] > 4'd3))) ? 4'd0 : v[DW-1:0];
    return {h, l};
  endfunction

  function automatic logic [FW-1:0] next_hour(input logic [FW-1:0] v);
    logic [FW-1:0] c;
    c = clean_hour(v);
    if (c != v)                return c;
    if (v == 8'h23)            return 8'h00;
    if (v[DW-1:0] == 4'd9)     return {v[FW-1:DW] + 4'd1, 4'd0};
    return {v[FW-1:DW], v[DW-1:0] + 4'd1};
  endfunction
`endif

  // Two-flop synchronisers plus previous-value registers for edge detection
  always_ff @(posedge CP or negedge _CR) begin
    if (!_CR) begin
      meta_q <= '0;
      sync_q <= '0;
      prev_q <= '0;
    end else begin
      meta_q <= {adj_hour, adj_min, CP_1Hz_in};
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign tick       = sync_q[0] & ~prev_q[0];
  assign adj_min_e  = sync_q[1] & ~prev_q[1];
  assign adj_hour_e = sync_q[2] & ~prev_q[2];

  always_comb begin
    sec_d       = sec_q;
    min_d       = min_q;
    hour_d      = hour_q;
    sec_pulse_d = 1'b0;
    day_carry_d = 1'b0;
`ifdef CLK_12H_EN
    pm_d        = pm_q;
    hour_last   = (hour_q == 8'h11) && pm_q;
`else
    hour_last   = (hour_q == 8'h23);
`endif
    tick_apply  = tick & ~hold;
    any_event   = tick_apply | adj_min_e | adj_hour_e;

    // An adjust in the same cycle overrides the carry into its field
    sec_wrap    = tick_apply && (sec_q == 8'h59);
    min_tick    = sec_wrap && !adj_min_e;
    min_wrap    = min_tick && (min_q == 8'h59);
    hour_inc    = adj_hour_e || min_wrap;

    if (tick_apply) begin
      sec_d       = next60(sec_q);
      sec_pulse_d = 1'b1;
    end else if (any_event) begin
      sec_d = clean60(sec_q);
    end

    if (adj_min_e || min_tick) begin
      min_d = next60(min_q);
    end else if (any_event) begin
      min_d = clean60(min_q);
    end

    if (hour_inc) begin
      hour_d = next_hour(hour_q);
`ifdef CLK_12H_EN
      if (hour_q == 8'h11) begin
        pm_d = ~pm_q;
      end
`endif
    end else if (any_event) begin
      hour_d = clean_hour(hour_q);
    end

    day_carry_d = min_wrap && !adj_hour_e && hour_last;
  end

  always_ff @(posedge CP or negedge _CR) begin
    if (!_CR) begin
      sec_q       <= '0;
      min_q       <= INIT_MIN;
      hour_q      <= INIT_HOUR;
      sec_pulse_q <= 1'b0;
      day_carry_q <= 1'b0;
`ifdef CLK_12H_EN
      pm_q        <= 1'b0;
`endif
    end else begin
      sec_q       <= sec_d;
      min_q       <= min_d;
      hour_q      <= hour_d;
      sec_pulse_q <= sec_pulse_d;
      day_carry_q <= day_carry_d;
`ifdef CLK_12H_EN
      pm_q        <= pm_d;
`endif
    end
  end

  assign sec_l     = sec_q[DW-1:0];
  assign sec_h     = sec_q[FW-1:DW];
  assign min_l     = min_q[DW-1:0];
  assign min_h     = min_q[FW-1:DW];
  assign hour_l    = hour_q[DW-1:0];
  assign hour_h    = hour_q[FW-1:DW];
  assign sec_pulse = sec_pulse_q;
  assign day_carry = day_carry_q;
`ifdef CLK_12H_EN
  assign pm        = pm_q;
`endif

endmodule
